// File: rtl/wino_pkg.sv
// Shared types and constants for the Winograd output-side tile accumulator.
package wino_pkg;
  localparam int TILE   = 6;
  localparam int DATA_W = 12;
  localparam int ACC_W  = 16;
  localparam int OD_W   = 8;
  localparam int IDX_W  = 9;
  localparam int CNT_W  = 5;
  localparam int IJ_W   = 3;

  typedef logic [TILE-1:0][TILE-1:0][DATA_W-1:0] res_tile_t;
  typedef logic [TILE-1:0][TILE-1:0][ACC_W-1:0]  acc_tile_t;

  typedef struct packed {
    logic [OD_W-1:0]  od;
    logic [IDX_W-1:0] x;
    logic [IDX_W-1:0] y;
    logic             size;
  } tile_tag_t;

  typedef enum logic [1:0] {EMPTY, ACCUM, FULL} bank_state_e;
  typedef enum logic {IDLE, DRAIN} drain_state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/tile_bank.sv
// One accumulation bank: 6x6 accumulators, group tag, tile count and fill state.
module tile_bank
  import wino_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             free,
  input  res_tile_t        tile,
  input  tile_tag_t        tag_in,
  input  logic [CNT_W-1:0] cfg,
  output bank_state_e      state,
  output acc_tile_t        acc,
  output tile_tag_t        tag,
  output logic             fills,
  output logic             mismatch
);
  logic [CNT_W-1:0] cnt, cfg_q, cfg_eff;

  assign cfg_eff  = (cfg == '0) ? CNT_W'(1) : cfg;
  // fills marks the add that completes the group, so the top can flip fill_ptr on the same edge
  assign fills    = load && ((state == EMPTY) ? (cfg_eff == CNT_W'(1))
                                              : ((cnt + CNT_W'(1)) == cfg_q));
  assign mismatch = load && (state == ACCUM) && (tag_in != tag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      acc   <= '0;
      tag   <= '0;
      cnt   <= '0;
      cfg_q <= '0;
    end else if (free) begin
      state <= EMPTY;
      cnt   <= '0;
    end else if (load) begin
      for (int i = 0; i < TILE; i++)
        for (int j = 0; j < TILE; j++)
          acc[i][j] <= (state == EMPTY) ? sext(tile[i][j]) : acc[i][j] + sext(tile[i][j]);
      state <= fills ? FULL : ACCUM;
      if (state == EMPTY) begin
        tag   <= tag_in;
        cfg_q <= cfg_eff;
        cnt   <= CNT_W'(1);
      end else begin
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/tile_accumulator.sv
// Double-buffered ID-loop tile accumulator with saturating valid/ready element drain.
module tile_accumulator
  import wino_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         cfg_id_num_i,
  input  logic                     res_valid_i,
  input  res_tile_t                res_tile_i,
  input  logic                     res_size_type_i,
  input  logic [OD_W-1:0]          res_od_i,
  input  logic [IDX_W-1:0]         res_x_i,
  input  logic [IDX_W-1:0]         res_y_i,
  output logic                     wr_valid_o,
  input  logic                     wr_ready_i,
  output logic signed [DATA_W-1:0] wr_data_o,
  output logic [OD_W-1:0]          wr_od_o,
  output logic [IDX_W-1:0]         wr_row_o,
  output logic [IDX_W-1:0]         wr_col_o,
  output logic                     wr_last_o,
  output logic                     ovf_o,
  output logic                     tag_err_o,
  output logic                     busy_o
);
  bank_state_e  st  [2];
  acc_tile_t    acc [2];
  tile_tag_t    tag [2];
  logic [1:0]   load, free, fills, mism;
  tile_tag_t    tag_in;
  logic         fill_ptr, drain_ptr, ptr_d, last, done;
  drain_state_e ds, ds_d;
  logic [IJ_W-1:0] i_q, j_q, i_d, j_d, n_m1;
  acc_tile_t    dacc;
  tile_tag_t    dtag;

  assign tag_in = '{od: res_od_i, x: res_x_i, y: res_y_i, size: res_size_type_i};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    // a FULL bank never loads, so load and free never meet on one bank
    assign load[b] = res_valid_i && (fill_ptr == 1'(b)) && (st[b] != FULL);
    assign free[b] = done && (drain_ptr == 1'(b));
    tile_bank u_bank (
      .clk(clk), .reset(reset), .load(load[b]), .free(free[b]),
      .tile(res_tile_i), .tag_in(tag_in), .cfg(cfg_id_num_i),
      .state(st[b]), .acc(acc[b]), .tag(tag[b]),
      .fills(fills[b]), .mismatch(mism[b])
    );
  end

  assign busy_o = (st[0] != EMPTY) || (st[1] != EMPTY);
  assign dacc   = acc[drain_ptr];
  assign dtag   = tag[drain_ptr];
  assign n_m1   = dtag.size ? IJ_W'(3) : IJ_W'(5);
  assign last   = (i_q == n_m1) && (j_q == n_m1);
  assign done   = (ds == DRAIN) && wr_ready_i && last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_ptr  <= 1'b0;
      ovf_o     <= 1'b0;
      tag_err_o <= 1'b0;
    end else begin
      if (|fills) fill_ptr <= ~fill_ptr;
      if (res_valid_i && st[fill_ptr] == FULL) ovf_o <= 1'b1;
      if (|mism) tag_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ds        <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      drain_ptr <= 1'b0;
    end else begin
      ds        <= ds_d;
      i_q       <= i_d;
      j_q       <= j_d;
      drain_ptr <= ptr_d;
    end
  end

  always_comb begin
    ds_d  = ds;
    i_d   = i_q;
    j_d   = j_q;
    ptr_d = drain_ptr;
    case (ds)
      IDLE: if (st[drain_ptr] == FULL) begin
        ds_d = DRAIN;
        i_d  = '0;
        j_d  = '0;
      end
      DRAIN: if (wr_ready_i) begin
        if (last) begin
          ds_d  = IDLE;
          ptr_d = ~drain_ptr;
        end else if (j_q == n_m1) begin
          j_d = '0;
          i_d = i_q + IJ_W'(1);
        end else begin
          j_d = j_q + IJ_W'(1);
        end
      end
      default: ds_d = IDLE;
    endcase
  end

  always_comb begin
    wr_valid_o = 1'b0;
    wr_data_o  = '0;
    wr_od_o    = '0;
    wr_row_o   = '0;
    wr_col_o   = '0;
    wr_last_o  = 1'b0;
    if (ds == DRAIN) begin
      wr_valid_o = 1'b1;
      wr_data_o  = sat(dacc[i_q][j_q]);
      wr_od_o    = dtag.od;
      wr_row_o   = dtag.x + IDX_W'(i_q);
      wr_col_o   = dtag.y + IDX_W'(j_q);
      wr_last_o  = last;
    end
  end
endmodule

// File: tb/tb_tile_accumulator.sv
// Directed table-driven bench for tile_accumulator plus overflow, tag-error and reset sequences.
module tb_tile_accumulator;
  import wino_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [CNT_W-1:0] cfg_id_num_i = '0;
  logic res_valid_i = 1'b0;
  res_tile_t res_tile_i = '0;
  logic res_size_type_i = 1'b0;
  logic [OD_W-1:0] res_od_i = '0;
  logic [IDX_W-1:0] res_x_i = '0, res_y_i = '0;
  logic wr_valid_o, wr_ready_i, wr_last_o, ovf_o, tag_err_o, busy_o;
  logic signed [DATA_W-1:0] wr_data_o;
  logic [OD_W-1:0] wr_od_o;
  logic [IDX_W-1:0] wr_row_o, wr_col_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tile_accumulator dut (
    .clk(clk), .reset(reset), .cfg_id_num_i(cfg_id_num_i), .res_valid_i(res_valid_i),
    .res_tile_i(res_tile_i), .res_size_type_i(res_size_type_i), .res_od_i(res_od_i),
    .res_x_i(res_x_i), .res_y_i(res_y_i), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .wr_data_o(wr_data_o), .wr_od_o(wr_od_o), .wr_row_o(wr_row_o), .wr_col_o(wr_col_o),
    .wr_last_o(wr_last_o), .ovf_o(ovf_o), .tag_err_o(tag_err_o), .busy_o(busy_o)
  );

  typedef struct {
    int cfg; bit size; int ntiles; int val; bit pat;
    int od; int x; int y; int exp;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic res_tile_t build(input int val, input bit pat);
    res_tile_t t;
    logic [DATA_W-1:0] v;
    for (int i = 0; i < TILE; i++)
      for (int j = 0; j < TILE; j++) begin
        v = pat ? DATA_W'(i*6 + j) : DATA_W'(val);
        t[i][j] = v;
      end
    return t;
  endfunction

  // called at a negedge; leaves res_valid_i high for back-to-back use
  task automatic drive_tile(input int cfg, input bit size, input int val, input bit pat,
                            input int od, input int x, input int y);
    cfg_id_num_i    = CNT_W'(cfg);
    res_size_type_i = size;
    res_tile_i      = build(val, pat);
    res_od_i        = OD_W'(od);
    res_x_i         = IDX_W'(x);
    res_y_i         = IDX_W'(y);
    res_valid_i     = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain_check(input string nm, input bit size, input bit pat, input int exp,
                             input int od, input int x, input int y);
    int n = size ? 4 : 6;
    int t;
    for (int e = 0; e < n*n; e++) begin
      int i = e / n;
      int j = e % n;
      t = 0;
      while (!wr_valid_o && t < 200) begin @(negedge clk); t++; end
      if (!wr_valid_o) begin
        chk({nm, " timeout"}, 0, 1);
        return;
      end
      chk({nm, " data"}, int'(wr_data_o), pat ? i*6 + j : exp);
      chk({nm, " row"},  int'(wr_row_o), (x + i) % 512);
      chk({nm, " col"},  int'(wr_col_o), (y + j) % 512);
      chk({nm, " od"},   int'(wr_od_o), od);
      chk({nm, " last"}, int'(wr_last_o), (e == n*n-1) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{cfg: 3,  size: 0, ntiles: 3,  val: 100,   pat: 0, od: 5,   x: 0,   y: 6,   exp: 300};
    tbl[1] = '{cfg: 16, size: 0, ntiles: 16, val: 2047,  pat: 0, od: 1,   x: 10,  y: 20,  exp: 2047};
    tbl[2] = '{cfg: 16, size: 0, ntiles: 16, val: -2048, pat: 0, od: 200, x: 0,   y: 0,   exp: -2048};
    tbl[3] = '{cfg: 1,  size: 1, ntiles: 1,  val: 0,     pat: 1, od: 7,   x: 510, y: 3,   exp: 0};
    tbl[4] = '{cfg: 0,  size: 0, ntiles: 1,  val: -5,    pat: 0, od: 255, x: 506, y: 509, exp: -5};
    tbl[5] = '{cfg: 2,  size: 1, ntiles: 2,  val: 1000,  pat: 0, od: 3,   x: 0,   y: 0,   exp: 2000};

    wr_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset valid", int'(wr_valid_o), 0);
    chk("reset data",  int'(wr_data_o), 0);
    chk("reset busy",  int'(busy_o), 0);
    chk("reset ovf",   int'(ovf_o), 0);
    chk("reset tagerr", int'(tag_err_o), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < tbl[v].ntiles; k++)
        drive_tile(tbl[v].cfg, tbl[v].size, tbl[v].val, tbl[v].pat, tbl[v].od, tbl[v].x, tbl[v].y);
      res_valid_i = 1'b0;
      drain_check($sformatf("vec%0d", v), tbl[v].size, tbl[v].pat, tbl[v].exp,
                  tbl[v].od, tbl[v].x, tbl[v].y);
      chk($sformatf("vec%0d busy after", v), int'(busy_o), 0);
    end
    chk("no ovf yet", int'(ovf_o), 0);
    chk("no tagerr yet", int'(tag_err_o), 0);

    // both banks full with output stalled; third tile must be dropped
    wr_ready_i = 1'b0;
    drive_tile(1, 0, 11, 0, 2, 0, 0);
    drive_tile(1, 0, 22, 0, 3, 0, 0);
    drive_tile(1, 0, 33, 0, 4, 0, 0);
    res_valid_i = 1'b0;
    chk("ovf set", int'(ovf_o), 1);
    chk("ovf busy", int'(busy_o), 1);
    chk("stall valid", int'(wr_valid_o), 1);
    repeat (3) @(negedge clk);
    chk("stall hold valid", int'(wr_valid_o), 1);
    chk("stall hold data", int'(wr_data_o), 11);
    chk("stall hold row", int'(wr_row_o), 0);
    chk("stall hold col", int'(wr_col_o), 0);
    chk("stall hold od", int'(wr_od_o), 2);
    wr_ready_i = 1'b1;
    drain_check("ovf t1", 0, 0, 11, 2, 0, 0);
    drain_check("ovf t2", 0, 0, 22, 3, 0, 0);
    chk("ovf busy after", int'(busy_o), 0);
    chk("ovf sticky", int'(ovf_o), 1);

    // tag mismatch inside a group: tile still added, first tag kept
    drive_tile(2, 0, 10, 0, 4, 12, 0);
    chk("tagerr before", int'(tag_err_o), 0);
    drive_tile(2, 0, 20, 0, 9, 12, 0);
    res_valid_i = 1'b0;
    chk("tagerr set", int'(tag_err_o), 1);
    drain_check("tagerr", 0, 0, 30, 4, 12, 0);

    // reset in the middle of a drain
    drive_tile(1, 0, 7, 0, 1, 0, 0);
    res_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-rst valid", int'(wr_valid_o), 1);
    reset = 1'b0;
    #1;
    chk("mid-rst valid", int'(wr_valid_o), 0);
    chk("mid-rst data", int'(wr_data_o), 0);
    chk("mid-rst busy", int'(busy_o), 0);
    chk("mid-rst ovf", int'(ovf_o), 0);
    chk("mid-rst tagerr", int'(tag_err_o), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive_tile(1, 0, 9, 0, 6, 1, 2);
    res_valid_i = 1'b0;
    drain_check("post-rst", 0, 0, 9, 6, 1, 2);
    chk("post-rst busy", int'(busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tile_accumulator.md
# tile_accumulator

Output-side stage fed by the Winograd PE result port. It sums consecutive PE result tiles belonging to one output channel/position over the input-depth (ID) loop, double-buffered. Each completed tile is drained as a saturated element stream with valid/ready toward the output memory. The PE has no backpressure, so a new group accumulates in one bank while the other drains.

## Interface
- DATA_W, 12: PE result element width (signed)
- ACC_W, 16: accumulator element width (signed)
- TILE, 6: max tile edge
- OD_W, 8: output-channel index width
- IDX_W, 9: row/col index width
- CNT_W, 5: ID-count width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_id_num_i  in  CNT_W  tiles per group (1..16; 0 treated as 1), latched at group start
- res_valid_i  in  1  result tile valid (single-cycle, no backpressure)
- res_tile_i  in  DATA_W x [TILE][TILE]  signed result tile
- res_size_type_i  in  1  0 = 6x6 tile, 1 = 4x4 tile (rows/cols 0..3 used)
- res_od_i  in  OD_W  output channel
- res_x_i, res_y_i  in  IDX_W each  tile base row / col
- wr_valid_o  out  1  element valid
- wr_ready_i  in  1  memory accepts element
- wr_data_o  out  DATA_W  saturated element
- wr_od_o  out  OD_W; wr_row_o, wr_col_o  out  IDX_W  element address
- wr_last_o  out  1  last element of tile
- ovf_o  out  1  sticky: tile dropped, no free bank
- tag_err_o  out  1  sticky: od/x/y/size mismatch inside a group
- busy_o  out  1  any bank not EMPTY

## Operation
- Two banks, each: ACC_W x 36 accumulators, tag (od, x, y, size), count, state EMPTY/ACCUM/FULL.
- fill_ptr selects accumulating bank; drain_ptr selects draining bank; both reset to 0.
- Tile arrival, fill bank EMPTY: bank <= sign-extended tile, tag/cfg latched, count = 1, state ACCUM.
- Tile arrival, fill bank ACCUM: elementwise add; count++; tag compared, mismatch sets tag_err_o, tile still added, tag unchanged.
- count reaches latched cfg_id_num: state FULL, fill_ptr toggles (same edge as the final add).
- Tile arrival with fill bank FULL: tile dropped, ovf_o set, no state change.
- Sums exact: 16 x 12-bit fits ACC_W=16; no wrap.
- Drain FSM: IDLE -> DRAIN when bank[drain_ptr] FULL; DRAIN walks i,j row-major, N = 6 or 4 per tag size; after last handshake bank -> EMPTY, drain_ptr toggles, FSM -> IDLE.
- wr_data_o = acc saturated to [-2048, 2047]; wr_row_o = x+i, wr_col_o = y+j, mod 2^IDX_W.
- Reset: all outputs 0, banks EMPTY, counters 0, sticky flags clear; mid-drain reset abandons the tile.

## Timing
- Accumulate: 1-cycle; back-to-back res_valid_i every cycle supported.
- wr_valid_o rises the cycle after bank becomes FULL; 1 element/cycle while wr_ready_i high; 36 (or 16) cycles minimum per tile.
- valid/ready: wr_valid_o and all wr_* held stable until wr_ready_i; no retraction.
- Bank freed on last-handshake edge; a tile arriving that same cycle into that bank is dropped (state sampled pre-edge).
- Drain and accumulate proceed concurrently on opposite banks.
- IDLE -> DRAIN of the other FULL bank: 1 bubble cycle.

## Structure
- wino_pkg: TILE, DATA_W, ACC_W, OD_W, IDX_W; typedefs acc_tile_t, tile_tag_t; enum bank_state_e {EMPTY, ACCUM, FULL}; sat function.
- Sub-module tile_bank (storage, tag, count, state, add/load); instantiated twice; top holds pointers, drain FSM, flags.

## Test plan
- cfg=3, three 6x6 tiles all 100, od=5 x=0 y=6, ready=1 -> 36 writes of 300, rows 0..5, cols 6..11, wr_last_o on 36th.
- cfg=16, 16 tiles all 2047 -> accum 32752, writes 2047 (saturated); all -2048 -> -2048.
- size=1, cfg=1, tile[i][j]=i*6+j -> 16 writes only, values 0,1,2,3,6,...,21.
- cfg=1, tile every cycle, ready=0 -> banks fill after 2 tiles, 3rd tile sets ovf_o, busy_o=1; release ready -> both tiles drain correctly.
- cfg=2, second tile od differs -> tag_err_o=1, sum written at first od.
- Reset asserted mid-drain -> all outputs 0 immediately, next group drains normally.
